// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Central hazard/stall controller for a 5-stage in-order pipeline.
//            Resolves load-use hazards, taken-branch flushes, data-memory wait
//            states (with timeout abort) and debug halt / single-step with a
//            back-end drain before 'halted' is reported.
// Ports    : clk, rstn                 - clock, async active-low reset
//            idex_memread, idex_rd     - load in ID/EX and its destination
//            ifid_rs1/rs2, ifid_use_*  - IF/ID source registers and usage
//            branch_taken              - taken branch/jump resolved at EX/MEM
//            dmem_req, dmem_ready      - MEM-stage access handshake
//            dbg_halt, dbg_step        - debug halt level / single-step pulse
//            pc_en, ifid_en, exmem_en  - stage-register load enables
//            ifid_flush, idex_flush,
//            memwb_bubble              - NOP insertion controls
//            stall, halted, mem_timeout, stall_count - status
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
   parameter int MEM_TIMEOUT  = 16,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        idex_memread,
   input  logic [4:0]  idex_rd,
   input  logic [4:0]  ifid_rs1,
   input  logic [4:0]  ifid_rs2,
   input  logic        ifid_use_rs1,
   input  logic        ifid_use_rs2,
   input  logic        branch_taken,
   input  logic        dmem_req,
   input  logic        dmem_ready,
   input  logic        dbg_halt,
   input  logic        dbg_step,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        exmem_en,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        memwb_bubble,
   output logic        stall,
   output logic        halted,
   output logic        mem_timeout,
   output logic [15:0] stall_count
);

   localparam int c_WAIT_W  = $clog2(MEM_TIMEOUT + 2);
   localparam int c_DRAIN_W = $clog2(DRAIN_CYCLES + 2);

   // The wait counter holds the number of frozen cycles already spent on the
   // current access, so the cycle that sees MEM_TIMEOUT-1 is the last one.
   localparam logic [c_WAIT_W-1:0]  c_WAIT_LAST = c_WAIT_W'(MEM_TIMEOUT - 1);
   localparam logic [c_WAIT_W-1:0]  c_WAIT_ONE  = c_WAIT_W'(1);
   localparam logic [c_DRAIN_W-1:0] c_DRAIN_SAT = c_DRAIN_W'(DRAIN_CYCLES);
   localparam logic [c_DRAIN_W-1:0] c_DRAIN_ONE = c_DRAIN_W'(1);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_MEMWAIT = 2'd1,
      ST_HALT    = 2'd2,
      ST_STEP    = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_WAIT_W-1:0]  r_wait_cnt;
   logic [c_WAIT_W-1:0]  w_wait_nxt;
   logic [c_DRAIN_W-1:0] r_drain_cnt;
   logic [c_DRAIN_W-1:0] w_drain_nxt;
   logic                 r_lu_done;
   logic                 r_mem_timeout;
   logic [15:0]          r_stall_count;

   logic w_mem_busy;
   logic w_hazard;
   logic w_halted;
   logic w_lu_stall;
   logic w_timeout_hit;

   assign w_mem_busy = dmem_req & ~dmem_ready;

   // x0 is never a real dependency, so rd==0 cannot cause a hazard.
   assign w_hazard = idex_memread & (idex_rd != 5'd0) &
                     ((ifid_use_rs1 & (ifid_rs1 == idex_rd)) |
                      (ifid_use_rs2 & (ifid_rs2 == idex_rd)));

   assign w_halted = (r_state == ST_HALT) & (r_drain_cnt >= c_DRAIN_SAT);

   always_comb begin
      w_state_nxt   = r_state;
      w_wait_nxt    = r_wait_cnt;
      w_drain_nxt   = r_drain_cnt;
      w_lu_stall    = 1'b0;
      w_timeout_hit = 1'b0;
      pc_en         = 1'b1;
      ifid_en       = 1'b1;
      exmem_en      = 1'b1;
      ifid_flush    = 1'b0;
      idex_flush    = 1'b0;
      memwb_bubble  = 1'b0;
      stall         = 1'b0;

      case (r_state)
         ST_RUN: begin
            w_wait_nxt = '0;
            if (w_mem_busy) begin
               pc_en        = 1'b0;
               ifid_en      = 1'b0;
               exmem_en     = 1'b0;
               memwb_bubble = 1'b1;
               stall        = 1'b1;
               w_wait_nxt   = c_WAIT_ONE;
               w_state_nxt  = ST_MEMWAIT;
            end else begin
               if (branch_taken) begin
                  // The stalled younger instruction is squashed anyway.
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
               end else if (w_hazard && !r_lu_done) begin
                  // r_lu_done limits each hazard to one bubble even if the
                  // ID/EX inputs are not updated in the following cycle.
                  pc_en      = 1'b0;
                  ifid_en    = 1'b0;
                  idex_flush = 1'b1;
                  stall      = 1'b1;
                  w_lu_stall = 1'b1;
               end
               if (dbg_halt) begin
                  w_drain_nxt = '0;
                  w_state_nxt = ST_HALT;
               end
            end
         end

         ST_MEMWAIT: begin
            if (dmem_ready) begin
               w_wait_nxt  = '0;
               w_state_nxt = ST_RUN;
            end else begin
               pc_en        = 1'b0;
               ifid_en      = 1'b0;
               exmem_en     = 1'b0;
               memwb_bubble = 1'b1;
               stall        = 1'b1;
               if (r_wait_cnt >= c_WAIT_LAST) begin
                  w_timeout_hit = 1'b1;
                  w_wait_nxt    = '0;
                  w_state_nxt   = ST_RUN;
               end else begin
                  w_wait_nxt = r_wait_cnt + c_WAIT_ONE;
               end
            end
         end

         ST_HALT: begin
            if (w_mem_busy) begin
               // Memory freeze while draining: drain progress is held.
               pc_en        = 1'b0;
               ifid_en      = 1'b0;
               exmem_en     = 1'b0;
               memwb_bubble = 1'b1;
               stall        = 1'b1;
            end else begin
               pc_en      = 1'b0;
               ifid_en    = 1'b0;
               idex_flush = 1'b1;
               stall      = 1'b1;
               if (r_drain_cnt < c_DRAIN_SAT) begin
                  w_drain_nxt = r_drain_cnt + c_DRAIN_ONE;
               end
               if (!dbg_halt) begin
                  w_state_nxt = ST_RUN;
               end else if (w_halted && dbg_step) begin
                  w_state_nxt = ST_STEP;
               end
            end
         end

         ST_STEP: begin
            w_drain_nxt = '0;
            w_state_nxt = ST_HALT;
         end

         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase

      // While reset is held the pipeline registers are kept loaded with NOPs.
      if (!rstn) begin
         pc_en        = 1'b0;
         ifid_en      = 1'b0;
         exmem_en     = 1'b0;
         ifid_flush   = 1'b1;
         idex_flush   = 1'b1;
         memwb_bubble = 1'b1;
         stall        = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state       <= ST_RUN;
         r_wait_cnt    <= '0;
         r_drain_cnt   <= '0;
         r_lu_done     <= 1'b0;
         r_mem_timeout <= 1'b0;
         r_stall_count <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_wait_cnt    <= w_wait_nxt;
         r_drain_cnt   <= w_drain_nxt;
         r_lu_done     <= w_lu_stall;
         r_mem_timeout <= r_mem_timeout | w_timeout_hit;
         if (stall && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
         end
      end
   end

   assign halted      = rstn & w_halted;
   assign mem_timeout = r_mem_timeout;
   assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, meaning max consecutive MEMWAIT cycles before abort.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3, meaning back-end drain cycles before halted asserts.
REQ-003 SHALL provide ports, one per line:
- clk  in  1  single clock, all state on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- idex_memread  in  1  ID/EX holds a load.
- idex_rd  in  5  ID/EX destination register.
- ifid_rs1, ifid_rs2  in  5 each  IF/ID source registers.
- ifid_use_rs1, ifid_use_rs2  in  1 each  source actually read.
- branch_taken  in  1  branch/jump resolved taken at EX/MEM.
- dmem_req  in  1  MEM stage issues data-memory access.
- dmem_ready  in  1  data memory completes this cycle.
- dbg_halt  in  1  level debug halt request.
- dbg_step  in  1  single-step pulse, honoured only when halted.
- pc_en, ifid_en, exmem_en  out  1 each  stage-register load enables.
- ifid_flush, idex_flush, memwb_bubble  out  1 each  insert NOP into that register.
- stall  out  1  front end frozen this cycle.
- halted  out  1  pipeline fully drained in HALT.
- mem_timeout  out  1  sticky, memory wait aborted.
- stall_count  out  16  saturating count of stall cycles.

Function
REQ-004 SHALL implement FSM states RUN, MEMWAIT, HALT, STEP; control outputs are combinational from state and current inputs.
REQ-005 RUN default: pc_en=ifid_en=exmem_en=1, all flush/bubble=0, stall=0.
REQ-006 Load-use in RUN: idex_memread & idex_rd!=0 & ((ifid_use_rs1 & rs1==rd) | (ifid_use_rs2 & rs2==rd)) -> pc_en=0, ifid_en=0, idex_flush=1, stall=1, exactly one cycle per hazard.
REQ-007 branch_taken in RUN -> ifid_flush=1, idex_flush=1, pc_en=1; overrides load-use stall in the same cycle (stall=0).
REQ-008 RUN & dmem_req & !dmem_ready -> pc_en=ifid_en=exmem_en=0, memwb_bubble=1, stall=1, next state MEMWAIT; has priority over branch and load-use.
REQ-009 MEMWAIT: same freeze outputs; branch_taken ignored; dmem_ready=1 -> outputs as RUN for that cycle (freeze released), next RUN.
REQ-010 MEMWAIT wait counter SHALL count cycles; reaching MEM_TIMEOUT without dmem_ready -> mem_timeout=1 (sticky until reset), next RUN.
REQ-011 dbg_halt=1 in RUN with no MEMWAIT entry -> next HALT; HALT outputs pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, stall=1.
REQ-012 HALT drain counter SHALL increment each cycle from 0, saturating; halted=1 when counter>=DRAIN_CYCLES.
REQ-013 HALT & halted & dbg_step -> next STEP; STEP outputs RUN defaults for exactly one cycle, then HALT with drain counter cleared.
REQ-014 HALT & dbg_halt=0 -> next RUN; halted deasserts in the cycle RUN is entered; dbg_step ignored when halted=0.
REQ-015 dmem_req & !dmem_ready in HALT SHALL freeze as REQ-008 but remain in HALT and hold the drain counter.
REQ-016 stall_count SHALL increment on every cycle stall=1, saturating at 0xFFFF.

Reset
REQ-017 rstn low SHALL immediately force state RUN, counters 0, halted=0, mem_timeout=0, stall=0, stall_count=0, pc_en=ifid_en=exmem_en=0, ifid_flush=idex_flush=memwb_bubble=1.
REQ-018 Reset asserted mid-MEMWAIT or mid-HALT SHALL abandon that state with no residual stall after release.
REQ-019 First rising edge after rstn rises SHALL see RUN default outputs.

Verification
REQ-020 idex_memread=1, idex_rd=5, ifid_rs1=5, ifid_use_rs1=1 for one cycle -> pc_en=0, idex_flush=1, stall=1 that cycle only; stall_count=1.
REQ-021 Load-use condition plus branch_taken=1 same cycle -> ifid_flush=idex_flush=1, pc_en=1, stall=0, stall_count unchanged.
REQ-022 dmem_req=1, dmem_ready low 4 cycles then high -> 4 frozen cycles with memwb_bubble=1, release on 5th, stall_count=4.
REQ-023 dmem_req=1, dmem_ready never high -> mem_timeout=1 after 16 cycles, state RUN, mem_timeout stays 1.
REQ-024 dbg_halt=1 -> halted=1 after 3 HALT cycles; dbg_step pulse -> one cycle pc_en=1, halted=0 for 3 cycles then 1; dbg_halt=0 -> RUN.
REQ-025 rstn pulled low during MEMWAIT -> outputs per REQ-017 asynchronously; after release RUN with stall=0.
